// File: rtl/fetch_ctrl.sv
// Instruction fetch/sequencing controller: IDLE/RUN/HALTED FSM, PC-relative branches on a latched compare flag.
// Optional retired-instruction counter is compiled in when RETIRED_COUNT_EN is defined.
module fetch_ctrl #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [8:0]       instr,
  input  logic [1:0]       compare_flag,
  input  logic             alu_halt,
  output logic [PC_W-1:0]  pc,
  output logic [3:0]       alu_op,
  output logic [4:0]       alu_field,
  output logic             instr_valid,
  output logic [1:0]       flag_q,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [4:0] field;
  } instr_t;

  localparam logic [3:0] OP_CMP  = 4'd7;
  localparam logic [3:0] OP_BR   = 4'd9;
  localparam logic [3:0] OP_BEQ  = 4'd10;
  localparam logic [3:0] OP_BGT  = 4'd11;
  localparam logic [3:0] OP_BLT  = 4'd12;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [1:0] FLAG_NONE = 2'b11;
  localparam logic [1:0] FLAG_EQ   = 2'b10;
  localparam logic [1:0] FLAG_GT   = 2'b01;
  localparam logic [1:0] FLAG_LT   = 2'b00;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_d;
  logic [1:0]       flag_d;
  instr_t           cur;
  logic             taken;
  logic [PC_W-1:0]  offset;

  assign cur    = instr_t'(instr);
  // Offset field is a 5-bit two's-complement displacement; the add wraps modulo 2^PC_W.
  assign offset = {{(PC_W-5){cur.field[4]}}, cur.field};

  always_comb begin
    taken = 1'b0;
    case (cur.op)
      OP_BR:   taken = 1'b1;
      OP_BEQ:  taken = (flag_q == FLAG_EQ);
      OP_BGT:  taken = (flag_q == FLAG_GT);
      OP_BLT:  taken = (flag_q == FLAG_LT);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    flag_d  = flag_q;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
          flag_d  = FLAG_NONE;
        end
      end
      RUN: begin
        // Halt wins over branch and compare; pc stays on the halting address.
        if (cur.op == OP_HALT || alu_halt) begin
          state_d = HALTED;
        end else begin
          if (cur.op == OP_CMP) flag_d = compare_flag;
          pc_d = taken ? pc + offset : pc + PC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc      <= '0;
      flag_q  <= FLAG_NONE;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    instr_valid = (state_q == RUN);
    alu_op      = instr_valid ? cur.op    : 4'd0;
    alu_field   = instr_valid ? cur.field : 5'd0;
    done        = (state_q == HALTED);
  end

`ifdef RETIRED_COUNT_EN
  logic [CNT_W-1:0] retired_q;

  // Every RUN cycle retires one instruction, including the halting one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
    end else if (state_q != RUN && start) begin
      retired_q <= '0;
    end else if (state_q == RUN && retired_q != {CNT_W{1'b1}}) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a behavioural zero-wait ROM feeds instr from pc,
// expected values are hand-derived per step.
module tb_fetch_ctrl;
  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [8:0]       instr;
  logic [1:0]       compare_flag;
  logic             alu_halt;
  logic [PC_W-1:0]  pc;
  logic [3:0]       alu_op;
  logic [4:0]       alu_field;
  logic             instr_valid;
  logic [1:0]       flag_q;
  logic             done;
  logic [CNT_W-1:0] retired;

  logic [8:0] rom [1024];
  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .compare_flag(compare_flag), .alu_halt(alu_halt), .pc(pc),
    .alu_op(alu_op), .alu_field(alu_field), .instr_valid(instr_valid),
    .flag_q(flag_q), .done(done), .retired(retired)
  );

  always #5 clk = ~clk;
  assign instr = rom[pc];

  function automatic logic [8:0] mk(input int op, input int field);
    logic [3:0] o;
    logic [4:0] f;
    o = 4'(op);
    f = 5'(field);
    return {o, f};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 9'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [31:0] ret_exp(input int n);
`ifdef RETIRED_COUNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  initial begin
    clear_rom();
    reset = 1'b1; start = 1'b0; compare_flag = 2'b11; alu_halt = 1'b0;
    #3;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_flag", 32'(flag_q), 3);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_op", 32'(alu_op), 0);
    chk("rst_ret", 32'(retired), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_hold_pc", 32'(pc), 0);
    chk("idle_valid", 32'(instr_valid), 0);

    // Straight-line program ending in HALT; start mid-RUN is ignored.
    rom[0] = mk(1, 3); rom[1] = mk(2, 5); rom[2] = mk(15, 0);
    pulse_start();
    chk("a_pc0", 32'(pc), 0);
    chk("a_op0", 32'(alu_op), 1);
    chk("a_field0", 32'(alu_field), 3);
    chk("a_valid0", 32'(instr_valid), 1);
    tick();
    chk("a_pc1", 32'(pc), 1);
    chk("a_op1", 32'(alu_op), 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("a_pc2_start_ignored", 32'(pc), 2);
    chk("a_done_pre", 32'(done), 0);
    tick();
    chk("a_done", 32'(done), 1);
    chk("a_pc_hold", 32'(pc), 2);
    chk("a_valid_halt", 32'(instr_valid), 0);
    chk("a_op_halt", 32'(alu_op), 0);
    chk("a_ret", 32'(retired), ret_exp(3));
    tick();
    chk("a_pc_hold2", 32'(pc), 2);

    // Compare then BEQ +3: taken with A==B.
    clear_rom();
    rom[0] = mk(7, 0); rom[1] = mk(10, 3); rom[4] = mk(15, 0);
    compare_flag = 2'b10;
    pulse_start();
    chk("b_pc0", 32'(pc), 0);
    chk("b_done0", 32'(done), 0);
    chk("b_ret_clr", 32'(retired), 0);
    tick();
    chk("b_pc1", 32'(pc), 1);
    chk("b_flag", 32'(flag_q), 2);
    tick();
    chk("b_pc_taken", 32'(pc), 4);
    tick();
    chk("b_done", 32'(done), 1);
    chk("b_ret", 32'(retired), ret_exp(3));

    // Same program, A>B: BEQ not taken.
    rom[2] = mk(15, 0);
    compare_flag = 2'b01;
    pulse_start();
    chk("c_flag_restart", 32'(flag_q), 3);
    tick();
    chk("c_flag", 32'(flag_q), 1);
    tick();
    chk("c_pc_nt", 32'(pc), 2);
    tick();
    chk("c_done", 32'(done), 1);

    // Branch chain: BGT with no compare, negative offsets, wrap below 0 and past 1023.
    clear_rom();
    rom[0]    = mk(9, 5);
    rom[5]    = mk(11, 3);
    rom[6]    = mk(9, 5'b11101);
    rom[3]    = mk(9, 5'b10000);
    rom[1011] = mk(12, 2);
    rom[1012] = mk(9, 11);
    pulse_start();
    chk("d_flag_restart", 32'(flag_q), 3);
    tick();
    chk("d_pc5", 32'(pc), 5);
    tick();
    chk("d_bgt_nt", 32'(pc), 6);
    tick();
    chk("d_back3", 32'(pc), 3);
    tick();
    chk("d_wrap_neg", 32'(pc), 1011);
    tick();
    chk("d_blt_nt", 32'(pc), 1012);
    tick();
    chk("d_pc1023", 32'(pc), 1023);
    tick();
    chk("d_wrap_pos", 32'(pc), 0);
    chk("d_no_halt", 32'(done), 0);
    chk("d_valid", 32'(instr_valid), 1);
    alu_halt = 1'b1;
    tick();
    alu_halt = 1'b0;
    chk("d_ext_halt", 32'(done), 1);
    chk("d_ext_halt_pc", 32'(pc), 0);
    chk("d_ret", 32'(retired), ret_exp(8));

    // Branch offset 0 re-executes; alu_halt beats it.
    clear_rom();
    rom[4] = mk(9, 0);
    pulse_start();
    for (int i = 0; i < 4; i++) tick();
    chk("e_pc4", 32'(pc), 4);
    tick();
    chk("e_self", 32'(pc), 4);
    chk("e_run", 32'(done), 0);
    alu_halt = 1'b1;
    tick();
    alu_halt = 1'b0;
    chk("e_halt_pc", 32'(pc), 4);
    chk("e_done", 32'(done), 1);
    chk("e_ret", 32'(retired), ret_exp(6));

    // Async reset mid-RUN at pc=7 with a non-default flag.
    clear_rom();
    rom[0] = mk(7, 0);
    compare_flag = 2'b00;
    pulse_start();
    chk("f_restart_pc", 32'(pc), 0);
    chk("f_restart_done", 32'(done), 0);
    chk("f_restart_ret", 32'(retired), 0);
    for (int i = 0; i < 7; i++) tick();
    chk("f_pc7", 32'(pc), 7);
    chk("f_flag_lt", 32'(flag_q), 0);
    #2;
    reset = 1'b1;
    #1;
    chk("f_async_pc", 32'(pc), 0);
    chk("f_async_flag", 32'(flag_q), 3);
    chk("f_async_valid", 32'(instr_valid), 0);
    chk("f_async_ret", 32'(retired), 0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("f_idle_pc", 32'(pc), 0);
    chk("f_idle_valid", 32'(instr_valid), 0);
    chk("f_idle_done", 32'(done), 0);
    pulse_start();
    chk("f_run_valid", 32'(instr_valid), 1);
    tick();
    chk("f_run_pc1", 32'(pc), 1);
    chk("f_run_ret", 32'(retired), ret_exp(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PC_W, default 10, instruction address width in bits.
REQ-002 Parameter CNT_W, default 16, retired-instruction counter width.
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse that begins execution at address 0.
REQ-006 instr  input  9  instruction word from async instruction ROM: opcode [8:5], field [4:0].
REQ-007 compare_flag  input  2  ALU compare result: 11 none, 10 A==B, 01 A>B, 00 A<B.
REQ-008 alu_halt  input  1  ALU halt indication.
REQ-009 pc  output  PC_W  instruction ROM address.
REQ-010 alu_op  output  4  opcode forwarded to ALU.
REQ-011 alu_field  output  5  operand/immediate field forwarded to ALU.
REQ-012 instr_valid  output  1  high when alu_op/alu_field hold an executing instruction.
REQ-013 flag_q  output  2  latched compare flag.
REQ-014 done  output  1  high while halted.
REQ-015 retired  output  CNT_W  retired-instruction count.

Function
REQ-016 The block SHALL implement states IDLE, RUN, HALTED.
REQ-017 IDLE: start=1 -> RUN next edge with pc=0; otherwise hold.
REQ-018 RUN: one instruction per cycle; instr is sampled in the same cycle pc is presented (zero-wait ROM).
REQ-019 RUN: instr_valid=1, alu_op=instr[8:5], alu_field=instr[4:0], combinationally; outside RUN instr_valid=0, alu_op=0, alu_field=0.
REQ-020 Opcode 7 (compare) in RUN: flag_q <= compare_flag at the edge; the next instruction's branch evaluation uses the new value.
REQ-021 Opcode 9: unconditional branch; opcode 10 taken iff flag_q==10; opcode 11 taken iff flag_q==01; opcode 12 taken iff flag_q==00; flag_q==11 makes 10/11/12 not taken.
REQ-022 Taken branch: pc <= pc + sign_extend(instr[4:0]) modulo 2^PC_W (offset range -16..+15; offset 0 re-executes same address); not taken or non-branch: pc <= pc+1 modulo 2^PC_W.
REQ-023 Opcode 15 or alu_halt=1 in RUN: next state HALTED, pc holds the halting address; halt takes priority over any branch in the same cycle.
REQ-024 HALTED: done=1; start=1 -> RUN with pc=0, flag_q=11, done=0 next edge.
REQ-025 start while in RUN SHALL be ignored.
REQ-026 pc wrap from 2^PC_W-1 SHALL continue at 0 without halting.
REQ-027 Branches do not modify flag_q; only opcode 7 and reset/restart do.

Reset
REQ-028 reset=1 SHALL immediately force state=IDLE, pc=0, flag_q=11, done=0, retired=0, regardless of clk.
REQ-029 Reset mid-RUN SHALL abandon the current instruction without counting it; after release, execution resumes only on start.

Configuration
REQ-030 Macro RETIRED_COUNT_EN defined: retired increments once per RUN cycle (including the halting instruction), saturating at 2^CNT_W-1, cleared on restart from HALTED.
REQ-031 Macro RETIRED_COUNT_EN undefined: no counter register exists; retired is tied to 0.

Verification
REQ-032 Reset, start, ROM: 0:op1, 1:op2, 2:op15 -> pc 0,1,2 on consecutive cycles; done=1 from the cycle after address 2; pc stays 2; retired=3 (with macro).
REQ-033 addr 0 op7 with compare_flag=10, addr 1 op10 offset +3 -> pc goes 0,1,4; same with compare_flag=01 -> pc 0,1,2.
REQ-034 op11 at addr 5 before any compare (flag_q=11) -> not taken, pc=6; op9 offset -16 at addr 3 with PC_W=10 -> pc=1011 binary... i.e. 1011 decimal (wrap 3-16 mod 1024).
REQ-035 op9 offset 0 at addr 4 with alu_halt=1 in same cycle -> HALTED, pc=4, done=1; start pulse -> pc=0, flag_q=11, done=0.
REQ-036 Assert reset asynchronously mid-RUN at pc=7 between edges -> pc=0, state IDLE, flag_q=11 immediately; start ignored in RUN; without RETIRED_COUNT_EN retired reads 0 throughout.
